// File: rtl/step_sequencer.sv
// ---------------------------------------------------------------------------
// step_sequencer
//   Multi-cycle control FSM for the simple 12-bit processor. It walks each
//   instruction through FETCH / DECODE / EXEC / MEM / WB and emits the Moore
//   strobes for the PC, IR, data memory, register file and ALU.
//
// Parameters
//   IW      instruction width (opcode in instr[11:9], ALU field in instr[8:6])
//   DM_LAT  extra data-memory read wait cycles for loads (0..3)
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous, active-low reset
//   step        single-step start pulse
//   run         1 = free-run, 0 = single-step
//   isexternal  external IM load; forces the sequencer back to IDLE
//   instr       current IR contents
//   ir_load     IR capture strobe (FETCH)
//   pc_en       PC advance strobe (WB)
//   DM_re       data memory read enable (LD in MEM and WB)
//   DM_we       data memory write enable (ST in MEM)
//   RF_we       register file write enable (ALU/LD in WB)
//   loadSignal  RF write-data select, 1 = memory (LD in WB)
//   ALU_op      ALU operation (EXEC/WB of an ALU instruction, else 000)
//   busy        high in any state other than IDLE and HALTED
//   halted      high in HALTED
//   illegal     sticky flag: an illegal opcode was decoded
//
// Optional feature macro: STEP_QUEUE_EN
//   When defined, a step pulse arriving while busy is remembered in a 1-deep
//   pending flag and starts the next instruction straight from WB.
// ---------------------------------------------------------------------------
module step_sequencer #(
    parameter int IW     = 12,
    parameter int DM_LAT = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          step,
    input  logic          run,
    input  logic          isexternal,
    input  logic [IW-1:0] instr,
    output logic          ir_load,
    output logic          pc_en,
    output logic          DM_re,
    output logic          DM_we,
    output logic          RF_we,
    output logic          loadSignal,
    output logic [2:0]    ALU_op,
    output logic          busy,
    output logic          halted,
    output logic          illegal
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALTED
    } state_t;

    localparam logic [2:0] OP_ST   = 3'b000;
    localparam logic [2:0] OP_LD   = 3'b001;
    localparam logic [2:0] OP_ALU  = 3'b010;
    localparam logic [2:0] OP_NOP  = 3'b011;
    localparam logic [2:0] OP_HALT = 3'b111;
    localparam logic [1:0] LAT     = DM_LAT[1:0];

    state_t     state_q, state_d;
    logic [2:0] op_q, op_d;
    logic [2:0] fn_q, fn_d;
    logic [1:0] wait_q, wait_d;
    logic       illegal_q, illegal_d;
    logic       take_queued;
    logic       in_busy;

    // Only instr[11:6] is decoded; the remaining bits belong to the datapath.
    logic unused_instr_bits;
    assign unused_instr_bits = ^instr;

    assign in_busy = (state_q != S_IDLE) && (state_q != S_HALTED);

`ifdef STEP_QUEUE_EN
    logic pending_q, pending_d;
    logic pend_now;

    // A step seen during WB counts as pending in that same cycle, so it is
    // not stranded in the flag after the return to IDLE.
    always_comb begin
        pend_now    = pending_q | (step & in_busy);
        take_queued = (state_q == S_WB) && !run && pend_now;
        if (isexternal || take_queued) pending_d = 1'b0;
        else                           pending_d = pend_now;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) pending_q <= 1'b0;
        else        pending_q <= pending_d;
    end
`else
    assign take_queued = 1'b0;
`endif

    // State and latched-instruction registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            op_q      <= OP_NOP;
            fn_q      <= 3'b000;
            wait_q    <= 2'b00;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            fn_q      <= fn_d;
            wait_q    <= wait_d;
            illegal_q <= illegal_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        fn_d      = fn_q;
        wait_d    = 2'b00;
        illegal_d = illegal_q;
        case (state_q)
            S_IDLE:   if (step || run) state_d = S_FETCH;
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                op_d = instr[11:9];
                fn_d = instr[8:6];
                case (instr[11:9])
                    OP_ALU:        state_d = S_EXEC;
                    OP_ST, OP_LD:  state_d = S_MEM;
                    OP_HALT:       state_d = S_HALTED;
                    OP_NOP:        state_d = S_WB;
                    default: begin
                        state_d   = S_WB;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_EXEC:   state_d = S_WB;
            S_MEM: begin
                // Loads hold MEM for LAT+1 cycles; stores leave after one.
                if (op_q == OP_LD && wait_q != LAT) wait_d = wait_q + 2'd1;
                else                                state_d = S_WB;
            end
            S_WB:     state_d = (run || take_queued) ? S_FETCH : S_IDLE;
            S_HALTED: state_d = S_HALTED;
            default:  state_d = S_IDLE;
        endcase

        // External IM loading aborts whatever is in flight, except HALTED.
        if (isexternal && state_q != S_HALTED) begin
            state_d   = S_IDLE;
            wait_d    = 2'b00;
            op_d      = op_q;
            fn_d      = fn_q;
            illegal_d = illegal_q;
        end
    end

    // Moore outputs
    always_comb begin
        ir_load    = 1'b0;
        pc_en      = 1'b0;
        DM_re      = 1'b0;
        DM_we      = 1'b0;
        RF_we      = 1'b0;
        loadSignal = 1'b0;
        ALU_op     = 3'b000;
        case (state_q)
            S_FETCH: ir_load = 1'b1;
            S_EXEC:  if (op_q == OP_ALU) ALU_op = fn_q;
            S_MEM: begin
                DM_we = (op_q == OP_ST);
                DM_re = (op_q == OP_LD);
            end
            S_WB: begin
                pc_en = 1'b1;
                if (op_q == OP_ALU) begin
                    RF_we  = 1'b1;
                    ALU_op = fn_q;
                end
                if (op_q == OP_LD) begin
                    RF_we      = 1'b1;
                    loadSignal = 1'b1;
                    DM_re      = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign busy    = in_busy;
    assign halted  = (state_q == S_HALTED);
    assign illegal = illegal_q;

endmodule

// File: doc/step_sequencer.md
Name: step_sequencer

Overview:
Multi-cycle FSM that sequences the single-cycle processor datapath through FETCH/DECODE/EXEC/MEM/WB phases.
- Generates PC advance, IR load, data-memory and register-file strobes from the 12-bit instruction.
- Supports single-step (button pulse) and free-run modes.
- Yields to external instruction-memory loading and stops on a HALT opcode.
- Sits between the PC/IR and the data memory, register file and ALU.

Parameters:
IW, 12, instruction width
DM_LAT, 1, extra data-memory read wait cycles for loads (legal range 0-3)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
step  input  1  single-cycle start pulse (debounced nextinstruction)
run  input  1  level; 1 = free-run, 0 = single-step
isexternal  input  1  external IM load mode; forces sequencer idle
instr  input  IW  current IR contents
ir_load  output  1  IR capture strobe
pc_en  output  1  PC advance strobe
DM_re  output  1  data memory read enable
DM_we  output  1  data memory write enable
RF_we  output  1  register file write enable
loadSignal  output  1  RF write-data select: 1 = memory, 0 = ALU
ALU_op  output  3  ALU operation
busy  output  1  high in any state other than IDLE and HALTED
halted  output  1  high in HALTED
illegal  output  1  sticky: an illegal opcode was decoded

Behaviour:
Opcode decode, op = instr[11:9]:
- 000 ST
- 001 LD
- 010 ALU, with ALU_op = instr[8:6]
- 011 NOP
- 111 HALT
- 100/101/110 illegal: executed as NOP and sets `illegal`.

States and transitions:
- IDLE → FETCH: on `step`=1, or `run`=1.
- FETCH: `ir_load`=1 for 1 cycle; IR updates on the edge leaving FETCH.
- DECODE: 1 cycle. Op and instr[8:6] are latched into internal registers on the exit edge.
- DECODE → next state: ALU → EXEC; ST or LD → MEM; NOP or illegal → WB; HALT → HALTED.
- EXEC: 1 cycle; `ALU_op` driven from the latched field.
- MEM, ST: `DM_we`=1 for exactly 1 cycle.
- MEM, LD: `DM_re`=1 for DM_LAT+1 cycles, counted by a 2-bit wait counter.
- WB: 1 cycle, `pc_en`=1.
  - ALU: `RF_we`=1, `ALU_op` held.
  - LD: `RF_we`=1, `loadSignal`=1, `DM_re` held.
- WB → FETCH if `run`=1, else → IDLE.
- HALTED: absorbing. `pc_en` is not asserted, so the PC stays on the HALT instruction. Exit only via `reset`.

Instruction latency from FETCH entry:
- ALU and ST: 4 cycles
- LD: 4+DM_LAT cycles
- NOP: 3 cycles

Output and boundary rules:
- All strobes are Moore outputs of the state register and latched op. Strobes are 0 in every state not listed above.
- `ALU_op` = 000 outside EXEC/WB of an ALU instruction.
- `step` while `busy` or `halted`: ignored (dropped).
- `step` and `run` both high in IDLE: single start; thereafter behaviour follows `run`.
- `run` deasserted mid-instruction: the current instruction completes, then → IDLE.
- `isexternal`=1 in any non-HALTED state: next state is IDLE.
  - The aborted instruction issues no further strobes and no `pc_en`.
  - `step` and `run` are ignored while `isexternal`=1.
- `isexternal` in HALTED: no effect.
- `reset`=0, asynchronously at any time, including mid-instruction: state=IDLE, wait counter=0, latched op=NOP, `illegal`=0, all outputs 0.

Optional Feature:
STEP_QUEUE_EN
- Defined: a `step` pulse arriving while `busy` sets a 1-deep pending flag. Further pulses while pending are dropped.
  - On WB exit with `run`=0 and pending=1: go to FETCH and clear pending.
  - `isexternal` or `reset` clears pending.
- Undefined: no pending flag; busy-time steps are dropped.

Test Plan:
1. Reset low then high; `instr`=0x480 (ALU, op 010, ALU_op=010); one `step` → `ir_load` at cycle 0; `ALU_op`=010 at cycles 2-3; `RF_we`=1 and `pc_en`=1 at cycle 3 only; then IDLE, `busy`=0.
2. DM_LAT=1; `instr`=0x200 (LD); `step` → `DM_re`=1 for cycles 2-4; `RF_we`=1, `loadSignal`=1, `pc_en`=1 at cycle 4; total 5 cycles.
3. `run`=1; `instr`=0x000 (ST) → `DM_we` pulses at cycles 2, 6, 10, …. Set `instr`=0xE00 (HALT) → `halted`=1 and `pc_en` stays 0. Further `step` pulses change nothing until `reset`.
4. `instr`=0x800 (illegal) → executes as NOP (3 cycles, only `pc_en` strobe); `illegal`=1 and remains 1 across subsequent instructions until `reset`.
5. LD in MEM; assert `isexternal` → next cycle IDLE; no `RF_we` or `pc_en` issued. `step` during `isexternal` is ignored.
6. STEP_QUEUE_EN: two `step` pulses during one ALU instruction, `run`=0 → exactly one extra instruction follows back-to-back (FETCH directly after WB). Without the macro, the sequencer returns to IDLE.
